backend_read_return_buffer: RTL and testbench

// - Sits directly downstream of the backend controller's returned-data channel and feeds the frontend scheduler.
// - Captures every read beat the backend produces. The backend has no ready input, so every valid beat must be taken.
// - Returns beats in order to the frontend using a valid/ready handshake.
// - Drives the backend's stall input early enough that reads already in flight can never overrun the buffer.

---
 rtl/frontend_cmd_definition_pkg.sv | 10 +
 rtl/backend_read_return_buffer.sv | 80 ++++++++
 tb/tb_backend_read_return_buffer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/frontend_cmd_definition_pkg.sv
// Shared definitions for the frontend/backend command and read-return path.
package frontend_cmd_definition_pkg;

  localparam int RETURN_BUF_DATA_W       = 128;
  localparam int RETURN_BUF_DEPTH        = 8;
  localparam int RETURN_BUF_STALL_MARGIN = 3;

  typedef logic [RETURN_BUF_DATA_W-1:0] read_beat_t;

endpackage

// File: rtl/backend_read_return_buffer.sv
// In-order show-ahead buffer between the backend read-return channel and the frontend.
// Asserts a registered stall early enough that in-flight reads never overrun it.
module backend_read_return_buffer
  import frontend_cmd_definition_pkg::*;
#(
  parameter int DATA_W       = RETURN_BUF_DATA_W,
  parameter int DEPTH        = RETURN_BUF_DEPTH,
  parameter int STALL_MARGIN = RETURN_BUF_STALL_MARGIN
) (
  input  logic                       clk,
  input  logic                       power_on_rst,
  input  logic [DATA_W-1:0]          i_backend_read_data,
  input  logic                       i_backend_read_data_valid,
  output logic                       o_backend_controller_stall,
  output logic [DATA_W-1:0]          o_frontend_read_data,
  output logic                       o_frontend_read_data_valid,
  input  logic                       i_frontend_controller_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
  output logic                       o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;
  logic             overflow_q, overflow_d;

  logic push, pop, push_acc, full, valid;

  assign valid = (count_q != '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  always_comb begin
    push     = i_backend_read_data_valid;
    pop      = valid & i_frontend_controller_ready;
    // At full a push only fits if the head leaves in the same cycle.
    push_acc = push & (~full | pop);

    wr_ptr_d   = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push_acc) - CNT_W'(pop);
    stall_d    = (CNT_W'(DEPTH) - count_d) <= CNT_W'(STALL_MARGIN);
    overflow_d = overflow_q | (push & ~push_acc);
  end

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  // Data array carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_acc && !power_on_rst) begin
      mem[wr_ptr_q] <= i_backend_read_data;
    end
  end

  assign o_frontend_read_data       = mem[rd_ptr_q];
  assign o_frontend_read_data_valid = valid;
  assign o_backend_controller_stall = stall_q;
  assign o_occupancy                = count_q;
  assign o_overflow                 = overflow_q;

endmodule

// File: tb/tb_backend_read_return_buffer.sv
// Directed bench for backend_read_return_buffer with hand-computed expectations.
module tb_backend_read_return_buffer;

  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              power_on_rst;
  logic [DATA_W-1:0] i_backend_read_data;
  logic              i_backend_read_data_valid;
  logic              o_backend_controller_stall;
  logic [DATA_W-1:0] o_frontend_read_data;
  logic              o_frontend_read_data_valid;
  logic              i_frontend_controller_ready;
  logic [3:0]        o_occupancy;
  logic              o_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  backend_read_return_buffer dut (
    .clk                         (clk),
    .power_on_rst                (power_on_rst),
    .i_backend_read_data         (i_backend_read_data),
    .i_backend_read_data_valid   (i_backend_read_data_valid),
    .o_backend_controller_stall  (o_backend_controller_stall),
    .o_frontend_read_data        (o_frontend_read_data),
    .o_frontend_read_data_valid  (o_frontend_read_data_valid),
    .i_frontend_controller_ready (i_frontend_controller_ready),
    .o_occupancy                 (o_occupancy),
    .o_overflow                  (o_overflow)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic rdy);
    i_backend_read_data_valid   = v;
    i_backend_read_data         = d;
    i_frontend_controller_ready = rdy;
  endtask

  task automatic do_reset();
    power_on_rst = 1'b1;
    tick();
    tick();
    power_on_rst = 1'b0;
  endtask

  initial begin
    power_on_rst = 1'b1;
    drive(1'b1, 128'hDEAD, 1'b0);
    tick();
    tick();
    power_on_rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("rst_valid", o_frontend_read_data_valid, 0);
    check("rst_occ", o_occupancy, 0);
    check("rst_stall", o_backend_controller_stall, 0);
    check("rst_ovf", o_overflow, 0);

    // Streaming with ready held high: output trails input by one cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 128'hA0 + i, 1'b1);
      tick();
      $display("stream push %0h", 128'hA0 + i);
      check("stream_data", o_frontend_read_data, 128'hA0 + i);
      check("stream_valid", o_frontend_read_data_valid, 1);
      check("stream_occ", o_occupancy, 1);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    check("stream_empty", o_frontend_read_data_valid, 0);
    check("stream_occ0", o_occupancy, 0);

    // Fill with ready low: stall once free space <= 3.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 128'hB0 + k - 1, 1'b0);
      tick();
      $display("fill push %0h occ %0d", 128'hB0 + k - 1, o_occupancy);
      check("fill_occ", o_occupancy, k);
      check("fill_stall", o_backend_controller_stall, (k >= 5) ? 1 : 0);
    end
    check("fill_ovf_clear", o_overflow, 0);
    drive(1'b1, 128'hEE, 1'b0);
    tick();
    $display("overflow push ee");
    check("ovf_set", o_overflow, 1);
    check("ovf_occ", o_occupancy, 8);

    // Head held stable under backpressure.
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_data", o_frontend_read_data, 128'hB0);
      check("hold_valid", o_frontend_read_data_valid, 1);
    end

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1);
      check("drain_data", o_frontend_read_data, 128'hB0 + i);
      tick();
      $display("drain pop %0h", 128'hB0 + i);
      check("drain_occ", o_occupancy, 7 - i);
      check("drain_stall", o_backend_controller_stall, (i <= 2) ? 1 : 0);
    end
    check("drain_empty", o_frontend_read_data_valid, 0);
    check("ovf_sticky", o_overflow, 1);

    // Simultaneous push and pop at full.
    do_reset();
    check("ovf_cleared", o_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 128'hC0 + i, 1'b0);
      tick();
    end
    check("full_occ", o_occupancy, 8);
    drive(1'b1, 128'hD0, 1'b1);
    tick();
    $display("full push d0 with pop c0");
    check("fullpp_occ", o_occupancy, 8);
    check("fullpp_ovf", o_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1);
      check("fullpp_data", o_frontend_read_data, (i == 7) ? 128'hD0 : 128'hC1 + i);
      tick();
    end
    check("fullpp_empty", o_frontend_read_data_valid, 0);

    // Asynchronous reset part-way through a 4-beat drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 128'hE0 + i, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    tick();
    tick();
    check("mid_occ", o_occupancy, 2);
    #2;
    power_on_rst = 1'b1;
    #1;
    $display("async reset mid drain");
    check("async_valid", o_frontend_read_data_valid, 0);
    check("async_stall", o_backend_controller_stall, 0);
    check("async_occ", o_occupancy, 0);
    tick();
    power_on_rst = 1'b0;
    drive(1'b1, 128'hF5, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("post_data", o_frontend_read_data, 128'hF5);
    check("post_valid", o_frontend_read_data_valid, 1);
    check("post_occ", o_occupancy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
